// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
// Shared definitions for the multiply/divide unit:
//   - muldiv_op_t    : MULDIVOp encodings as delivered by the EX-stage decoder
//   - muldiv_state_t : control FSM states
//   - DIV_CYCLES     : quotient bits resolved by the divider (one per cycle)
//   - abs32()        : magnitude of a 32-bit operand, honouring signedness
// Optional feature macro used by the unit: MULDIV_CANCEL_EN.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    SIGNED_MUL   = 2'b00,
    UNSIGNED_MUL = 2'b01,
    SIGNED_DIV   = 2'b10,
    UNSIGNED_DIV = 2'b11
  } muldiv_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_t;

  localparam int DIV_CYCLES = 32;

  // Signed operands are reduced to magnitudes so both multiply and divide
  // datapaths can work unsigned; 32'h8000_0000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
// Decoder/hazard-side bundle of the multiply/divide unit.
//   master : EX decoder side (drives start/op/operands/mt* writes/cancel,
//            reads busy and HI/LO)
//   slave  : muldiv_unit side
// Signals:
//   start, op, a, b        launch an operation on rs (a) / rt (b)
//   hilo_we, hilo_sel,     mthi (hilo_sel=1) / mtlo (hilo_sel=0) write
//   wdata
//   cancel                 abort in-flight operation (MULDIV_CANCEL_EN only)
//   busy                   operation in flight
//   hi, lo                 architectural HI/LO registers
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic        start;
  muldiv_op_t  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] wdata;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hilo_we, hilo_sel, wdata, cancel,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, hilo_we, hilo_sel, wdata, cancel,
    output busy, hi, lo
  );

endinterface

// File: rtl/muldiv_unit_divider.sv
// muldiv_divider
// Iterative restoring radix-2 unsigned 32-bit divider, one quotient bit per
// clock. A load pulse captures the operands; DIV_CYCLES edges later done is
// high and quotient/remainder are valid until the next load.
// A zero divisor yields quotient 32'hFFFF_FFFF and remainder = dividend.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture dividend/divisor and restart
//   dividend, divisor   unsigned operands
//   quotient, remainder results
//   done                all quotient bits resolved
module muldiv_divider
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam logic [5:0] LAST_COUNT = 6'(DIV_CYCLES);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic [5:0]  count_q;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        step_ok;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the subtraction only when it does not go negative.
  // The partial remainder is always below the divisor, so 33 bits suffice.
  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, dsr_q};
    step_ok   = ~diff[32];
  end

  // Quotient bits are shifted into the low end of the dividend register as
  // the dividend bits leave the top, so one register holds both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      count_q <= '0;
    end else if (load) begin
      rem_q   <= '0;
      quo_q   <= dividend;
      dsr_q   <= divisor;
      count_q <= '0;
    end else if (count_q != LAST_COUNT) begin
      rem_q   <= step_ok ? diff[31:0] : rem_shift[31:0];
      quo_q   <= {quo_q[30:0], step_ok};
      count_q <= count_q + 6'd1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = (count_q == LAST_COUNT);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Multiply results land in {hi,lo} MUL_CYCLES+1 cycles after start; divides
// (lo = quotient, hi = remainder) land 35 cycles after start. HI/LO keep
// their old values until the final DONE cycle.
// Parameters:
//   MUL_CYCLES  cycles from start until the product is committed (1..8)
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    muldiv_unit_if.slave (start/op/a/b, mthi/mtlo, cancel, busy, hi, lo)
// Configuration:
//   MULDIV_CANCEL_EN  when defined, bus.cancel aborts any in-flight operation
//                     and suppresses a simultaneous start; otherwise ignored.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 5
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES);

  muldiv_state_t state;
  muldiv_state_t state_next;
  logic [5:0]    cnt;
  logic [5:0]    cnt_next;
  logic          busy_q;

  muldiv_op_t    op_q;
  logic [31:0]   a_raw;
  logic [31:0]   a_abs;
  logic [31:0]   b_abs;
  logic          b_zero;
  logic          res_neg;
  logic          rem_neg;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  logic          abort;
  logic          accept;
  logic          fix_en;
  logic          commit;
  logic          hilo_wr;
  logic          in_signed;

  logic [31:0]   div_quo;
  logic [31:0]   div_rem;
  logic          div_done;
  logic [63:0]   product_raw;
  logic [63:0]   product;

`ifdef MULDIV_CANCEL_EN
  assign abort = bus.cancel;
`else
  logic cancel_unused;
  assign abort         = 1'b0;
  assign cancel_unused = bus.cancel;
`endif

  assign in_signed = ~bus.op[0];

  // Next-state and control decode. A start in IDLE takes priority over an
  // mthi/mtlo write in the same cycle; the write is simply dropped. With a
  // single-cycle multiply the MUL state is skipped so the product still
  // commits MUL_CYCLES cycles after start.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    fix_en     = 1'b0;
    commit     = 1'b0;
    hilo_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !abort) begin
          accept   = 1'b1;
          cnt_next = 6'd1;
          if (bus.op[1]) begin
            state_next = DIV;
          end else begin
            state_next = (MUL_CYCLES == 1) ? DONE : MUL;
          end
        end else if (bus.hilo_we && !bus.start) begin
          hilo_wr = 1'b1;
        end
      end
      MUL: begin
        if (abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == MUL_LAST) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 6'd1;
        end
      end
      DIV: begin
        if (abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == DIV_LAST) begin
          state_next = FIX;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 6'd1;
        end
      end
      FIX: begin
        if (abort) begin
          state_next = IDLE;
        end else if (div_done) begin
          fix_en     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        commit     = ~abort;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, step counter and the registered busy flag seen by the hazard unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      busy_q <= (state_next != IDLE);
    end
  end

  // Operands are captured as magnitudes plus result sign flags: the quotient
  // and product are negative when the operand signs differ, the remainder
  // follows the dividend. The raw dividend is kept for divide-by-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= SIGNED_MUL;
      a_raw   <= '0;
      a_abs   <= '0;
      b_abs   <= '0;
      b_zero  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
    end else if (accept) begin
      op_q    <= bus.op;
      a_raw   <= bus.a;
      a_abs   <= abs32(bus.a, in_signed);
      b_abs   <= abs32(bus.b, in_signed);
      b_zero  <= (bus.b == 32'd0);
      res_neg <= in_signed & (bus.a[31] ^ bus.b[31]);
      rem_neg <= in_signed & bus.a[31];
    end
  end

  muldiv_divider u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept & bus.op[1]),
    .dividend  (abs32(bus.a, in_signed)),
    .divisor   (abs32(bus.b, in_signed)),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // The product is formed from the stable latched magnitudes and only
  // sampled in DONE, so the multiplier has the whole MUL phase to settle.
  always_comb begin
    product_raw = {32'd0, a_abs} * {32'd0, b_abs};
    product     = res_neg ? (~product_raw + 64'd1) : product_raw;
  end

  // Sign fixup of the unsigned divider result. Divide by zero bypasses the
  // fixup so both signednesses give all-ones and the original dividend.
  // 32'h8000_0000 / -1 needs no special case: the magnitude quotient is
  // 32'h8000_0000 with a positive sign and a zero remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_hi <= '0;
      res_lo <= '0;
    end else if (fix_en) begin
      if (b_zero) begin
        res_lo <= 32'hFFFF_FFFF;
        res_hi <= a_raw;
      end else begin
        res_lo <= res_neg ? (~div_quo + 32'd1) : div_quo;
        res_hi <= rem_neg ? (~div_rem + 32'd1) : div_rem;
      end
    end
  end

  // Architectural HI/LO: written only by a completing operation in DONE or by
  // an mthi/mtlo accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      if (op_q[1]) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else begin
        hi_q <= product[63:32];
        lo_q <= product[31:0];
      end
    end else if (hilo_wr) begin
      if (bus.hilo_sel) begin
        hi_q <= bus.wdata;
      end else begin
        lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in EX, directly downstream of the EX-stage decoder.
- Consumes MULDIVstart, MULDIVOp, HILOWe and hilo from the decoder, plus the forwarded rs/rt operands.
- Provides HI/LO to the EX output mux (mfhi/mflo) and a busy signal to the hazard unit.

Parameters:
- MUL_CYCLES, 5, cycles from the start cycle until the product is committed to HI/LO (range 1..8).
- DIV_CYCLES, 32, quotient bits resolved; fixed at 32, one bit per cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch an operation (MULDIVstart)
- op  in  2  MULDIVOp: SIGNED_MUL / UNSIGNED_MUL / SIGNED_DIV / UNSIGNED_DIV
- a  in  32  rs operand (multiplicand or dividend)
- b  in  32  rt operand (multiplier or divisor)
- hilo_we  in  1  mthi/mtlo write enable (HILOWe)
- hilo_sel  in  1  1 = write HI, 0 = write LO (hilo)
- wdata  in  32  mthi/mtlo data
- cancel  in  1  abort the in-flight operation (exception/eret flush); active only with the optional feature
- busy  out  1  operation in flight; the hazard unit stalls mult/div/mf*/mt* in ID while busy or start
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: asynchronous, active-low. On reset, state=IDLE, busy=0, hi=0, lo=0, and all internal operand and counter registers are cleared. Reset mid-operation discards the operation.
- FSM states:
  - IDLE: start=1 latches op, a and b, then goes to MUL (op[1]=0) or DIV (op[1]=1). Signed ops latch |a| and |b| plus the result sign flags.
  - MUL: counter runs 1..MUL_CYCLES-1, then goes to DONE. The 64-bit product is computed from the latched operands and may be pipelined internally.
  - DIV: restoring radix-2, one quotient bit per cycle for 32 cycles, then goes to FIX.
  - FIX: applies sign correction, then goes to DONE.
  - DONE: writes HI/LO in the same cycle and returns to IDLE.
- busy = (state != IDLE), registered. It rises the cycle after start.
- Result visibility:
  - Multiply: hi/lo hold the product from cycle start+MUL_CYCLES+1 onward.
  - Divide: hi/lo hold the result from cycle start+35 onward (32 DIV cycles, 1 FIX, 1 DONE).
- Multiply result: {hi,lo} = 64-bit product, signed or unsigned per op.
- Divide result: lo = quotient, hi = remainder.
  - Quotient is truncated toward zero.
  - Remainder takes the dividend's sign.
- Divide by zero (b=0), either signedness: lo=32'hFFFF_FFFF, hi=a. No trap is raised.
- Signed overflow (a=32'h8000_0000, b=32'hFFFF_FFFF): lo=32'h8000_0000, hi=0.
- hilo_we in IDLE with start=0: hi or lo is written with wdata on the next edge.
- hilo_we while busy is ignored; the hazard unit guarantees it does not occur.
- start and hilo_we in the same cycle: start wins and the write is dropped.
- start while busy is ignored; the in-flight operation is unaffected.
- HI/LO are not modified until DONE; old values stay readable throughout the operation.

Optional Feature:
- Macro: MULDIV_CANCEL_EN.
- Defined: cancel=1 in any non-IDLE state forces IDLE on the next edge with no HI/LO write. busy falls the cycle after cancel.
  - cancel and start in the same IDLE cycle: start is suppressed.
  - cancel and DONE in the same cycle: the result is discarded.
- Undefined: cancel is ignored. Operations always complete; the pipeline drains the unit before taking an exception.

Decomposition:
- muldivop_def package: the MULDIVOp encodings SIGNED_MUL=2'b00, UNSIGNED_MUL=2'b01, SIGNED_DIV=2'b10, UNSIGNED_DIV=2'b11.
- Same package: FSM state localparams IDLE/MUL/DIV/FIX/DONE.
- Sub-module muldiv_divider: iterative restoring 32-bit unsigned divider core.
  - Inputs: load, dividend, divisor.
  - Outputs: quotient, remainder, done.
  - The top level handles sign absolute/fixup and the special cases.

Test Plan:
- Unsigned mult a=32'hFFFF_FFFF, b=2 → busy for MUL_CYCLES cycles, then hi=1, lo=32'hFFFF_FFFE.
- Signed div a=-7, b=2 → after 35 cycles lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). Old HI/LO remain stable while busy.
- Divu a=123, b=0 → lo=32'hFFFF_FFFF, hi=123. Signed div 32'h8000_0000 / -1 → lo=32'h8000_0000, hi=0.
- mthi 32'hDEAD_BEEF in IDLE → hi updated next cycle. The same write issued while busy, or together with start, leaves hi unchanged.
- rst_n pulsed low mid-divide (cycle 10) → hi=lo=0 and busy=0 immediately. A new start afterwards completes correctly.
- With MULDIV_CANCEL_EN: cancel at DIV cycle 5 → busy=0 the next cycle and hi/lo unchanged. Without the macro, the same stimulus completes normally.
